// File: rtl/seq_mult16_pkg.sv
// Shared types and constants for the 16x16 sequential multiplier.
// FSM state encoding, operand width and iteration count.
// Imported by the interface and the multiplier core.
package seq_mult16_pkg;

    localparam int OP_W  = 16;
    localparam int ITER  = 16;
    localparam int CNT_W = $clog2(ITER);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_mult16_if.sv
// Request/result bundle between a requester and seq_mult16.
// Master drives start/flush/operands; slave returns status and product.
// No internal storage; pure signal grouping.
interface seq_mult16_if;
    import seq_mult16_pkg::*;

    logic            start;
    logic            flush;
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
    logic            busy;
    logic            done;
    logic [OP_W-1:0] product_lo;
    logic [OP_W-1:0] product_hi;
    logic            zero;
    logic            neg;

    modport master (
        output start, flush, a, b,
        input  busy, done, product_lo, product_hi, zero, neg
    );

    modport slave (
        input  start, flush, a, b,
        output busy, done, product_lo, product_hi, zero, neg
    );

endinterface

// File: rtl/seq_mult16.sv
// Unsigned 16x16 -> 32 radix-2 shift-add multiplier, one bit per cycle.
// Latency: done pulses in the cycle after the 16th RUN edge, fixed.
// No backpressure: start is ignored while busy; flush aborts to IDLE.
module seq_mult16
    import seq_mult16_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    seq_mult16_if.slave  bus
);

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_count;
    logic [OP_W-1:0]    r_mcand;
    logic [OP_W-1:0]    r_mult;
    logic [2*OP_W-1:0]  r_acc;
    logic [OP_W-1:0]    r_product_lo;
    logic [OP_W-1:0]    r_product_hi;
    logic               r_zero;
    logic               r_neg;

    logic               w_accept;
    logic               w_last;
    logic               w_busy;
    logic               w_done;
    logic [OP_W:0]      w_sum;
    logic [2*OP_W-1:0]  w_acc_step;

    // One shift-add step: add multiplicand into the upper half with carry, then shift right.
    always_comb begin
        w_sum      = {1'b0, r_acc[2*OP_W-1:OP_W]} + (r_mult[0] ? {1'b0, r_mcand} : {(OP_W+1){1'b0}});
        w_acc_step = {w_sum, r_acc[OP_W-1:1]};
    end

    // Next-state and status decode; flush beats start, and start only counts outside RUN.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = (r_count == CNT_W'(ITER - 1));
        w_busy       = (r_state == RUN);
        w_done       = (r_state == DONE);
        case (r_state)
            IDLE: begin
                w_accept = bus.start;
                if (bus.start) w_state_next = RUN;
            end
            RUN: begin
                if (w_last) w_state_next = DONE;
            end
            DONE: begin
                w_accept     = bus.start;
                w_state_next = bus.start ? RUN : IDLE;
            end
            default: w_state_next = IDLE;
        endcase
        if (bus.flush) begin
            w_accept     = 1'b0;
            w_state_next = IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // Operand load, iteration, and result capture on the step that enters DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count      <= '0;
            r_mcand      <= '0;
            r_mult       <= '0;
            r_acc        <= '0;
            r_product_lo <= '0;
            r_product_hi <= '0;
            r_zero       <= 1'b1;
            r_neg        <= 1'b0;
        end else if (w_accept) begin
            r_count <= '0;
            r_mcand <= bus.a;
            r_mult  <= bus.b;
            r_acc   <= '0;
        end else if (r_state == RUN && !bus.flush) begin
            r_acc  <= w_acc_step;
            r_mult <= r_mult >> 1;
            if (w_last) begin
                r_product_lo <= w_acc_step[OP_W-1:0];
                r_product_hi <= w_acc_step[2*OP_W-1:OP_W];
                r_zero       <= ~|w_acc_step;
                r_neg        <= w_acc_step[2*OP_W-1];
            end else begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign bus.busy       = w_busy;
    assign bus.done       = w_done;
    assign bus.product_lo = r_product_lo;
    assign bus.product_hi = r_product_hi;
    assign bus.zero       = r_zero;
    assign bus.neg        = r_neg;

endmodule

// File: tb/tb_seq_mult16.sv
// Self-checking bench for seq_mult16: directed cases plus random operands.
// Reference model is plain 32-bit multiplication with held result registers.
// Inputs change on falling edges; outputs are sampled on falling edges.
module tb_seq_mult16;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [31:0] m_prod;
    logic        m_zero;
    logic        m_neg;

    seq_mult16_if bus ();

    seq_mult16 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_result(input logic [15:0] a, input logic [15:0] b);
        m_prod = {16'b0, a} * {16'b0, b};
        m_zero = (m_prod == 32'd0);
        m_neg  = m_prod[31];
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_lo"},   {16'b0, bus.product_lo}, {16'b0, m_prod[15:0]});
        check({tag, "_hi"},   {16'b0, bus.product_hi}, {16'b0, m_prod[31:16]});
        check({tag, "_zero"}, {31'b0, bus.zero},       {31'b0, m_zero});
        check({tag, "_neg"},  {31'b0, bus.neg},        {31'b0, m_neg});
    endtask

    task automatic do_start(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // Counts edges until done is seen (bounded); returns at the falling edge of the done cycle.
    task automatic wait_done(output int lat, output int busy_cnt, output logic seen);
        lat = 0; busy_cnt = 0; seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
            else begin
                if (bus.busy) busy_cnt++;
                @(posedge clk);
                lat++;
            end
        end
    endtask

    task automatic watch_quiet(input int n, output int dones, output int busys);
        dones = 0; busys = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
            if (bus.busy) busys++;
        end
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input string tag);
        int lat, bc;
        logic seen;
        do_start(a, b);
        wait_done(lat, bc, seen);
        model_result(a, b);
        check({tag, "_done_seen"}, {31'b0, seen}, 32'd1);
        check({tag, "_latency"}, lat, 32'd16);
        check({tag, "_busy_cycles"}, bc, 32'd16);
        check({tag, "_busy_in_done"}, {31'b0, bus.busy}, 32'd0);
        check_outputs(tag);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, {31'b0, bus.done}, 32'd0);
    endtask

    initial begin
        int lat, bc, dn, bz;
        logic seen;
        logic [15:0] ra, rb;

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        m_prod = 32'd0; m_zero = 1'b1; m_neg = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        check_outputs("rst");
        reset = 1'b0;

        // Basic timing and maximum operands.
        run_op(16'd3, 16'd5, "basic");
        run_op(16'hFFFF, 16'hFFFF, "max");

        // Zero product, then a new start accepted in the DONE cycle.
        run_op(16'h0000, 16'h1234, "zero");
        do_start(16'd9, 16'd9);
        wait_done(lat, bc, seen);
        bus.start = 1'b1; bus.a = 16'h0100; bus.b = 16'h0100;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done(lat, bc, seen);
        model_result(16'h0100, 16'h0100);
        check("b2b_done_seen", {31'b0, seen}, 32'd1);
        check("b2b_latency", lat, 32'd16);
        check_outputs("b2b");

        // Start while busy is ignored.
        do_start(16'd7, 16'd9);
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1; bus.a = 16'd1; bus.b = 16'd1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done(lat, bc, seen);
        model_result(16'd7, 16'd9);
        check("busy_start_seen", {31'b0, seen}, 32'd1);
        check("busy_start_latency", lat, 32'd11);
        check_outputs("busy_start");
        watch_quiet(20, dn, bz);
        check("busy_start_no_second_done", dn, 32'd0);
        check("busy_start_idle", bz, 32'd0);

        // Flush at RUN cycle 8: no done, outputs keep prior result.
        do_start(16'hBEEF, 16'h1357);
        repeat (7) @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        @(negedge clk);
        check("flush_busy", {31'b0, bus.busy}, 32'd0);
        watch_quiet(20, dn, bz);
        check("flush_no_done", dn, 32'd0);
        check("flush_no_busy", bz, 32'd0);
        check_outputs("flush_hold");

        // Flush wins over start in the same cycle.
        @(negedge clk);
        bus.flush = 1'b1; bus.start = 1'b1; bus.a = 16'd2; bus.b = 16'd2;
        @(posedge clk);
        #1 begin bus.flush = 1'b0; bus.start = 1'b0; end
        watch_quiet(20, dn, bz);
        check("flush_prio_no_busy", bz, 32'd0);
        check("flush_prio_no_done", dn, 32'd0);
        check_outputs("flush_prio");

        // Reset at RUN cycle 3.
        do_start(16'h8001, 16'h8001);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        m_prod = 32'd0; m_zero = 1'b1; m_neg = 1'b0;
        @(negedge clk);
        check("midrst_busy", {31'b0, bus.busy}, 32'd0);
        check_outputs("midrst");
        watch_quiet(20, dn, bz);
        check("midrst_no_done", dn, 32'd0);

        // Boundary and random operands.
        run_op(16'h8000, 16'd2, "b_carry");
        run_op(16'hFFFF, 16'd1, "b_one");
        for (int i = 0; i < 10; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            run_op(ra, rb, "rand");
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seq_mult16.md
SEQ_MULT16 -- requirements
Module: seq_mult16

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
REQ-004 start  in  1  request pulse; operands valid in the same cycle.
REQ-005 flush  in  1  abort of the current operation (pipeline flush on branch).
REQ-006 a  in  16  multiplicand (Rs1 data), unsigned.
REQ-007 b  in  16  multiplier (Rs2 data), unsigned.
REQ-008 busy  out  1  high while an operation is in progress; start is ignored.
REQ-009 done  out  1  one-cycle pulse; product and flags valid.
REQ-010 product_lo  out  16  product bits 15:0 (written to the ALU result 1 path).
REQ-011 product_hi  out  16  product bits 31:16 (written to the ALU result 2 path).
REQ-012 zero  out  1  product equals 0 (status bit 0 source).
REQ-013 neg  out  1  product bit 31 (status bit 1 source).

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-015 When start=1 in IDLE or DONE: a, b and a zeroed 32-bit accumulator are registered, the 4-bit count is cleared, and the FSM enters RUN.
REQ-016 In RUN, each cycle SHALL perform one radix-2 shift-add step: if multiplier LSB=1, add the multiplicand to the accumulator upper half with a 17-bit carry; then shift the accumulator and multiplier right by 1 together.
REQ-017 On the step with count=15, the FSM SHALL enter DONE; otherwise count increments.
REQ-018 Latency: start accepted at edge N -> done=1 in the cycle after edge N+16, fixed for all operand values, with no early termination.
REQ-019 done SHALL be 1 only in DONE; DONE lasts exactly one cycle, then goes to IDLE unless a new start is accepted.
REQ-020 busy SHALL equal 1 exactly while in RUN.
REQ-021 start while busy=1 SHALL be ignored, with no change to operands, count or outputs.
REQ-022 product_lo, product_hi, zero and neg SHALL hold their last completed values until the next DONE, including across IDLE, RUN and flush.
REQ-023 Output update: product_lo, product_hi, zero and neg SHALL update only on the edge entering DONE.
REQ-024 zero SHALL be the NOR of all 32 product bits; neg = product[31].
REQ-025 Flush: flush=1 in any state SHALL return the FSM to IDLE at the next edge, with no done pulse and outputs unchanged; flush has priority over start in the same cycle.
REQ-026 The result SHALL be exact modulo 2^32 for all 16-bit unsigned operands, and no overflow is possible.

Reset
REQ-027 reset=1 SHALL have priority over flush and start.
REQ-028 reset=1 SHALL force the FSM to IDLE and clear count, busy, done, product_lo, product_hi and neg to 0, and set zero to 1.
REQ-029 Reset asserted mid-operation SHALL abandon the operation with no done pulse.

Structure
REQ-030 A shared package SHALL hold the FSM state typedef (IDLE, RUN, DONE), the operand width constant 16, and the iteration count constant 16.
REQ-031 The block SHALL be a single module with no sub-module; the 17-bit step adder is inline.

Verification
REQ-032 Basic timing: a=3, b=5 with start pulsed at edge N -> done=1 after edge N+16; product_lo=0x000F, product_hi=0x0000, zero=0, neg=0; busy=1 for exactly 16 cycles.
REQ-033 Maximum operands: a=0xFFFF, b=0xFFFF -> product_hi=0xFFFE, product_lo=0x0001, neg=1, zero=0.
REQ-034 Zero product and back-to-back start: a=0, b=0x1234 -> zero=1, product=0. Then a start in the DONE cycle with a=0x0100, b=0x0100 -> next done after 16 further cycles; product_hi=0x0001, product_lo=0x0000.
REQ-035 Start while busy: start with a=7, b=9, then start with a=1, b=1 at RUN cycle 5 -> single done at the original time; product_lo=0x003F.
REQ-036 Flush and reset mid-operation: flush at RUN cycle 8 -> no done; outputs keep the prior result; busy=0 next cycle. Reset at RUN cycle 3 -> all outputs at reset values (zero=1) and no done for 20 cycles.
